issue_scoreboard: RTL

Issue stage feeding the 3-read/3-write register file. Takes a window of up to three decoded instructions in program order, checks them against a 32-entry busy scoreboard and against each other, issues the longest hazard-free in-order prefix, and registers the issued slots' source/destination specifiers onto the register-file read ports. Busy bits are set on issue and cleared by the same writeback signals (we/rw per pipeline) that drive register-file writes.

---
 rtl/issue_scoreboard_pkg.sv | 17 +
 rtl/issue_scoreboard_hazard_chk.sv | 39 +++
 rtl/issue_scoreboard.sv | 136 +++++++++++++
 3 files changed

// File: rtl/issue_scoreboard_pkg.sv
// Shared constants and types for the three-wide in-order issue stage and its
// 32-entry busy scoreboard.
package issue_scoreboard_pkg;

  localparam int NSLOT = 3;
  localparam int RW    = 5;
  localparam int NREGS = 32;

  localparam logic [RW-1:0] REG_ZERO = 5'd0;

  typedef logic [RW-1:0] reg_spec_t;

  function automatic logic is_nz(input reg_spec_t r);
    return (r != REG_ZERO);
  endfunction

endpackage

// File: rtl/issue_scoreboard_hazard_chk.sv
// Single-slot hazard check: scoreboard lookups for all used specifiers plus
// RAW/WAW comparison against the earlier slots of the same bundle.
module issue_scoreboard_hazard_chk
  import issue_scoreboard_pkg::*;
(
  input  logic                       vld_i,
  input  logic [RW-1:0]              rs_i,
  input  logic [RW-1:0]              rt_i,
  input  logic [RW-1:0]              rd_i,
  input  logic                       use_rs_i,
  input  logic                       use_rt_i,
  input  logic                       wr_rd_i,
  input  logic [NREGS-1:0]           busy_i,
  input  logic [NSLOT-2:0]           prv_wr_i,
  input  logic [NSLOT-2:0][RW-1:0]   prv_rd_i,
  output logic                       ok_o
);

  logic busy_hit_s;
  logic intra_hit_s;

  // Scoreboard lookups and in-bundle dependency against earlier slots
  always_comb begin
    busy_hit_s  = (use_rs_i & busy_i[rs_i]) |
                  (use_rt_i & busy_i[rt_i]) |
                  (wr_rd_i  & busy_i[rd_i]);
    intra_hit_s = 1'b0;
    for (int j = 0; j < NSLOT-1; j++) begin
      // a zero destination never creates a dependency
      intra_hit_s = intra_hit_s |
                    (prv_wr_i[j] & is_nz(prv_rd_i[j]) &
                     ((use_rs_i & (rs_i == prv_rd_i[j])) |
                      (use_rt_i & (rt_i == prv_rd_i[j])) |
                      (wr_rd_i  & (rd_i == prv_rd_i[j]))));
    end
    ok_o = vld_i & ~busy_hit_s & ~intra_hit_s;
  end

endmodule

// File: rtl/issue_scoreboard.sv
// Issue stage: selects the longest hazard-free in-order prefix of a 3-slot
// window, tracks destination busy bits and registers the read-port specifiers.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [NSLOT-1:0]           slot_vld_i,
  input  logic [NSLOT-1:0][RW-1:0]   slot_rs_i,
  input  logic [NSLOT-1:0][RW-1:0]   slot_rt_i,
  input  logic [NSLOT-1:0][RW-1:0]   slot_rd_i,
  input  logic [NSLOT-1:0]           slot_use_rs_i,
  input  logic [NSLOT-1:0]           slot_use_rt_i,
  input  logic [NSLOT-1:0]           slot_wr_rd_i,
  input  logic                       ex_stall_i,
  input  logic [NSLOT-1:0]           wb_we_i,
  input  logic [NSLOT-1:0][RW-1:0]   wb_rw_i,
  output logic [1:0]                 issue_cnt_o,
  output logic [NSLOT-1:0][RW-1:0]   ra_o,
  output logic [NSLOT-1:0][RW-1:0]   rb_o,
  output logic [NSLOT-1:0][RW-1:0]   rw_o,
  output logic [NSLOT-1:0]           we_o,
  output logic [NSLOT-1:0]           iss_vld_o
);

  logic [NSLOT-1:0]         slot_ok_s;
  logic [NSLOT-1:0]         issuable_s;
  logic [NSLOT-1:0]         issue_mask_s;
  logic [NREGS-1:0]         busy_q, busy_d;
  logic [NSLOT-1:0][RW-1:0] ra_q, ra_d, rb_q, rb_d, rw_q, rw_d;
  logic [NSLOT-1:0]         we_q, we_d, iss_vld_q, iss_vld_d;

  for (genvar k = 0; k < NSLOT; k++) begin : g_chk
    logic [NSLOT-2:0]         prv_wr_s;
    logic [NSLOT-2:0][RW-1:0] prv_rd_s;

    // Only slots older than k take part in its in-bundle comparison
    always_comb begin
      prv_wr_s = '0;
      prv_rd_s = '0;
      for (int j = 0; j < NSLOT-1; j++) begin
        if (j < k) begin
          prv_wr_s[j] = slot_wr_rd_i[j];
          prv_rd_s[j] = slot_rd_i[j];
        end else begin
          prv_wr_s[j] = 1'b0;
          prv_rd_s[j] = REG_ZERO;
        end
      end
    end

    issue_scoreboard_hazard_chk u_chk (
      .vld_i    (slot_vld_i[k]),
      .rs_i     (slot_rs_i[k]),
      .rt_i     (slot_rt_i[k]),
      .rd_i     (slot_rd_i[k]),
      .use_rs_i (slot_use_rs_i[k]),
      .use_rt_i (slot_use_rt_i[k]),
      .wr_rd_i  (slot_wr_rd_i[k]),
      .busy_i   (busy_q),
      .prv_wr_i (prv_wr_s),
      .prv_rd_i (prv_rd_s),
      .ok_o     (slot_ok_s[k])
    );
  end

  assign issuable_s   = {slot_ok_s[2] & slot_ok_s[1] & slot_ok_s[0],
                         slot_ok_s[1] & slot_ok_s[0],
                         slot_ok_s[0]};
  assign issue_mask_s = ex_stall_i ? 3'b000 : issuable_s;

  // Prefix length seen by the upstream window shifter
  always_comb begin
    case (issue_mask_s)
      3'b111:  issue_cnt_o = 2'd3;
      3'b011:  issue_cnt_o = 2'd2;
      3'b001:  issue_cnt_o = 2'd1;
      default: issue_cnt_o = 2'd0;
    endcase
  end

  // Scoreboard update (clear then set, so issue wins) and output latching
  always_comb begin
    busy_d    = busy_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    rw_d      = rw_q;
    we_d      = we_q;
    iss_vld_d = iss_vld_q;
    for (int n = 0; n < NSLOT; n++) begin
      busy_d[wb_rw_i[n]] = busy_d[wb_rw_i[n]] & ~wb_we_i[n];
    end
    for (int k = 0; k < NSLOT; k++) begin
      busy_d[slot_rd_i[k]] = busy_d[slot_rd_i[k]] | (issue_mask_s[k] & slot_wr_rd_i[k]);
    end
    busy_d[0] = 1'b0;
    if (!ex_stall_i) begin
      for (int k = 0; k < NSLOT; k++) begin
        iss_vld_d[k] = issue_mask_s[k];
        ra_d[k] = (issue_mask_s[k] & slot_use_rs_i[k]) ? slot_rs_i[k] : REG_ZERO;
        rb_d[k] = (issue_mask_s[k] & slot_use_rt_i[k]) ? slot_rt_i[k] : REG_ZERO;
        rw_d[k] = (issue_mask_s[k] & slot_wr_rd_i[k])  ? slot_rd_i[k] : REG_ZERO;
        we_d[k] = issue_mask_s[k] & slot_wr_rd_i[k] & is_nz(slot_rd_i[k]);
      end
    end else begin
      iss_vld_d = iss_vld_q;
      we_d      = we_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      busy_q    <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      rw_q      <= '0;
      we_q      <= '0;
      iss_vld_q <= '0;
    end else begin
      busy_q    <= busy_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      rw_q      <= rw_d;
      we_q      <= we_d;
      iss_vld_q <= iss_vld_d;
    end
  end

  assign ra_o      = ra_q;
  assign rb_o      = rb_q;
  assign rw_o      = rw_q;
  assign we_o      = we_q;
  assign iss_vld_o = iss_vld_q;

endmodule
